// File: rtl/data_mem_initiator_if.sv
// Request/response handshake between the MEM stage and the initiator,
// and the initiator-side bus of the little-endian word memory.
interface data_mem_initiator_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              stall;

    modport master (
        output req_valid, req_write, req_size, req_unsigned,
        output req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned,
        input  req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

interface data_mem_bus_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/data_mem_initiator.sv
// MEM-stage data memory initiator: byte/half/word loads and stores,
// sub-word stores done as read-modify-write on a word memory.
module data_mem_initiator #(
    parameter int ADDR_W = 32
) (
    input logic                  clk,
    input logic                  reset,
    data_mem_initiator_if.slave  req_if,
    data_mem_bus_if.master       mem_if
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic              err_q, err_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              mem_write_q, mem_write_d;

    logic              req_err;
    logic [31:0]       load_val;

    function automatic logic [31:0] merge(
        input logic [31:0] word,
        input logic [31:0] data,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] r;
        r = word;
        if (size == 2'b00) begin
            r[{lane, 3'b000} +: 8] = data[7:0];
        end else begin
            r[{lane[1], 4'b0000} +: 16] = data[15:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        uns,
        input logic [1:0]  lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        unique case (size)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_comb begin
        unique case (req_if.req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_if.req_addr[0];
            2'b10:   req_err = |req_if.req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        lane_d  = lane_q;
        err_d   = err_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_if.req_valid) begin
                    write_d = req_if.req_write;
                    size_d  = req_if.req_size;
                    uns_d   = req_if.req_unsigned;
                    lane_d  = req_if.req_addr[1:0];
                    err_d   = req_err;
                    addr_d  = {req_if.req_addr[ADDR_W-1:2], 2'b00};
                    if (req_if.req_write && !req_err) begin
                        wdata_d = req_if.req_wdata;
                    end
                    if (req_err) begin
                        state_d = S_DONE;
                    end else if (req_if.req_write && req_if.req_size == 2'b10) begin
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                word_d = mem_if.mem_rdata;
                // Sub-word stores fold the new lane(s) into the fetched word.
                if (write_q) begin
                    wdata_d = merge(mem_if.mem_rdata, wdata_q, size_q, lane_q);
                    state_d = S_SETUP;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SETUP: state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        mem_write_d = (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            lane_q      <= 2'b00;
            err_q       <= 1'b0;
            word_q      <= 32'h0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            err_q       <= err_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign load_val = extract(word_q, size_q, uns_q, lane_q);

    assign req_if.req_ready  = (state_q == S_IDLE);
    assign req_if.stall      = (state_q != S_IDLE);
    assign req_if.resp_valid = (state_q == S_DONE);
    assign req_if.resp_err   = (state_q == S_DONE) && err_q;
    assign req_if.resp_rdata =
        ((state_q == S_DONE) && !err_q && !write_q) ? load_val : 32'h0;

    assign mem_if.mem_addr  = addr_q;
    assign mem_if.mem_wdata = wdata_q;
    assign mem_if.mem_read  = (state_q == S_READ);
    assign mem_if.mem_write = mem_write_q;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Bench for data_mem_initiator: directed table, reset/back-to-back
// sequences and random traffic against a word-array reference model.
module tb_data_mem_initiator;

    logic clk = 1'b0;
    logic reset;

    data_mem_initiator_if #(.ADDR_W(32)) rif ();
    data_mem_bus_if #(.ADDR_W(32)) mif ();

    data_mem_initiator #(.ADDR_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .req_if (rif),
        .mem_if (mif)
    );

    always #5 clk = ~clk;

    bit [31:0] mem [1024];
    bit [31:0] ref_mem [1024];
    int        wr_cnt = 0;
    logic      poke_req = 1'b0;
    logic [9:0]  poke_idx;
    logic [31:0] poke_val;

    assign mif.mem_rdata = mif.mem_read ? mem[mif.mem_addr[11:2]] : 32'h0;

    always @(posedge mif.mem_write or posedge poke_req) begin
        if (poke_req) begin
            mem[poke_idx] <= poke_val;
        end else begin
            mem[mif.mem_addr[11:2]] <= mif.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        poke_idx = a[11:2];
        poke_val = v;
        ref_mem[a[11:2]] = v;
        poke_req = 1'b1;
        #1;
        poke_req = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            chk("rw_exclusive", 32'(mif.mem_read && mif.mem_write), 0);
            chk("stall_vs_ready", 32'(rif.stall), 32'(!rif.req_ready));
            if (!rif.resp_valid) begin
                chk("quiet_rdata", rif.resp_rdata, 0);
                chk("quiet_err", 32'(rif.resp_err), 0);
            end
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        rif.req_valid    = 1'b1;
        rif.req_write    = w;
        rif.req_size     = sz;
        rif.req_unsigned = u;
        rif.req_addr     = a;
        rif.req_wdata    = d;
    endtask

    task automatic run_txn(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd,
                           output logic err, output int wrs, output int rds,
                           output int wcyc);
        int w0;
        tick();
        chk("ready_before_req", 32'(rif.req_ready), 1);
        drive(w, sz, u, a, d);
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        rif.req_addr  = $urandom;
        rif.req_wdata = $urandom;
        lat = 0; rd = 0; err = 0; rds = 0; wcyc = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (mif.mem_read) rds++;
            if (mif.mem_write) wcyc = c;
            if (rif.resp_valid) begin
                lat = c;
                rd  = rif.resp_rdata;
                err = rif.resp_err;
                break;
            end
        end
        if (lat == 0) chk("resp_timeout", 0, 1);
        wrs = wr_cnt - w0;
    endtask

    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd,
                         output logic err, output int wrs, output int rds);
        int     off, idx, nb;
        longint word, span, field, v;
        off  = int'(a % 4);
        idx  = int'(a[11:2]);
        word = longint'(ref_mem[idx]);
        nb   = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        span = longint'(1) << (8 * nb);
        err  = (sz == 3) || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
        rd = 0; wrs = 0; rds = 0;
        if (err) begin
            lat = 1;
        end else if (!w) begin
            lat = 2;
            rds = 1;
            v = (word >> (8 * off)) % span;
            if (!u && nb < 4 && v >= span / 2) v = v - span;
            rd = v[31:0];
        end else begin
            wrs = 1;
            lat = (nb == 4) ? 3 : 4;
            rds = (nb == 4) ? 0 : 1;
            field = (word >> (8 * off)) % span;
            word = word - (field << (8 * off))
                 + ((longint'(d) % span) << (8 * off));
            ref_mem[idx] = word[31:0];
        end
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int          lat, wrs, rds, wcyc, e_lat, e_wrs, e_rds, w0;
        logic [31:0] rd, e_rd;
        logic        err, e_err;
        bit [7:0]    exp_stall, exp_resp;

        vecs[0]  = '{0, 2'b10, 0, 32'h100, 32'h0,        32'h8899AABB, 0, 2, 32'h8899AABB};
        vecs[1]  = '{0, 2'b00, 0, 32'h103, 32'h0,        32'hFFFFFF88, 0, 2, 32'h8899AABB};
        vecs[2]  = '{0, 2'b00, 1, 32'h103, 32'h0,        32'h00000088, 0, 2, 32'h8899AABB};
        vecs[3]  = '{1, 2'b00, 0, 32'h101, 32'h12,       32'h0,        0, 4, 32'h889912BB};
        vecs[4]  = '{0, 2'b01, 0, 32'h101, 32'h0,        32'h0,        1, 1, 32'h889912BB};
        vecs[5]  = '{1, 2'b10, 0, 32'h102, 32'h55555555, 32'h0,        1, 1, 32'h889912BB};
        vecs[6]  = '{0, 2'b01, 0, 32'h102, 32'h0,        32'hFFFF8899, 0, 2, 32'h889912BB};
        vecs[7]  = '{0, 2'b01, 1, 32'h100, 32'h0,        32'h000012BB, 0, 2, 32'h889912BB};
        vecs[8]  = '{0, 2'b11, 0, 32'h100, 32'h0,        32'h0,        1, 1, 32'h889912BB};
        vecs[9]  = '{1, 2'b01, 0, 32'h102, 32'h1234CAFE, 32'h0,        0, 4, 32'hCAFE12BB};
        vecs[10] = '{0, 2'b10, 1, 32'h100, 32'h0,        32'hCAFE12BB, 0, 2, 32'hCAFE12BB};
        vecs[11] = '{0, 2'b00, 0, 32'h100, 32'h0,        32'hFFFFFFBB, 0, 2, 32'hCAFE12BB};
        vecs[12] = '{1, 2'b00, 1, 32'h100, 32'hAB7F,     32'h0,        0, 4, 32'hCAFE127F};

        reset = 1'b1;
        drive(0, 2'b00, 0, 32'h0, 32'h0);
        rif.req_valid = 1'b0;
        poke(32'h100, 32'h8899AABB);
        poke(32'h200, 32'h11223344);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rif.req_ready), 1);
        chk("rst_stall", 32'(rif.stall), 0);
        chk("rst_resp_valid", 32'(rif.resp_valid), 0);
        chk("rst_resp_err", 32'(rif.resp_err), 0);
        chk("rst_resp_rdata", rif.resp_rdata, 0);
        chk("rst_mem_read", 32'(mif.mem_read), 0);
        chk("rst_mem_write", 32'(mif.mem_write), 0);
        chk("rst_mem_addr", mif.mem_addr, 0);
        chk("rst_mem_wdata", mif.mem_wdata, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_txn(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].d,
                    lat, rd, err, wrs, rds, wcyc);
            e_wrs = (vecs[i].w && !vecs[i].exp_err) ? 1 : 0;
            e_rds = (!vecs[i].exp_err && (!vecs[i].w || vecs[i].sz != 2'b10)) ? 1 : 0;
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_writes", i), wrs, e_wrs);
            chk($sformatf("vec%0d_reads", i), rds, e_rds);
            chk($sformatf("vec%0d_wcycle", i), wcyc,
                e_wrs ? vecs[i].exp_lat - 1 : 0);
            chk($sformatf("vec%0d_mem", i), mem[vecs[i].a[11:2]], vecs[i].exp_mem);
        end

        // Reset during SETUP of a word store, with req_valid held high.
        tick();
        drive(1, 2'b10, 0, 32'h200, 32'hDEADBEEF);
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        drive(0, 2'b10, 0, 32'h100, 32'h0);
        tick();
        chk("setup_stall", 32'(rif.stall), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_stall", 32'(rif.stall), 0);
        chk("abort_mem_write", 32'(mif.mem_write), 0);
        chk("abort_resp", 32'(rif.resp_valid), 0);
        @(posedge clk);
        #1;
        chk("rst_dominates_valid", 32'(rif.stall), 0);
        chk("rst_dominates_addr", mif.mem_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        rif.req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("abort_no_resp", 32'(rif.resp_valid), 0);
        end
        chk("abort_no_write", wr_cnt - w0, 0);
        chk("abort_mem_kept", mem[32'h200 >> 2], 32'h11223344);

        // Reset arriving while mem_write is high.
        tick();
        drive(1, 2'b00, 0, 32'h301, 32'h5A);
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        repeat (3) tick();
        chk("write_phase", 32'(mif.mem_write), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("wr_abort_mem_write", 32'(mif.mem_write), 0);
        chk("wr_abort_stall", 32'(rif.stall), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("wr_abort_no_resp", 32'(rif.resp_valid), 0);
        end

        // Back-to-back sw then lw with req_valid held.
        exp_stall = 8'b0110_1110;
        exp_resp  = 8'b0100_1000;
        tick();
        drive(1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        drive(0, 2'b10, 0, 32'h10, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk($sformatf("b2b_stall_c%0d", c), 32'(rif.stall), 32'(exp_stall[c]));
            chk($sformatf("b2b_resp_c%0d", c), 32'(rif.resp_valid), 32'(exp_resp[c]));
            if (c == 6) chk("b2b_lw_rdata", rif.resp_rdata, 32'hDEADBEEF);
            if (c == 4) begin
                @(posedge clk);
                #1;
                rif.req_valid = 1'b0;
            end
        end
        ref_mem[4] = 32'hDEADBEEF;
        chk("b2b_mem", mem[4], 32'hDEADBEEF);

        for (int i = 0; i < 300; i++) begin
            logic        w, u;
            logic [1:0]  sz;
            logic [31:0] a, d;
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom_range(0, 255);
            d  = $urandom;
            model(w, sz, u, a, d, e_lat, e_rd, e_err, e_wrs, e_rds);
            run_txn(w, sz, u, a, d, lat, rd, err, wrs, rds, wcyc);
            chk($sformatf("rnd%0d_lat", i), lat, e_lat);
            chk($sformatf("rnd%0d_rdata", i), rd, e_rd);
            chk($sformatf("rnd%0d_err", i), 32'(err), 32'(e_err));
            chk($sformatf("rnd%0d_writes", i), wrs, e_wrs);
            chk($sformatf("rnd%0d_reads", i), rds, e_rds);
            chk($sformatf("rnd%0d_mem", i), mem[a[11:2]], ref_mem[a[11:2]]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_initiator.md
DATA_MEM_INITIATOR -- requirements
Module: data_mem_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of request and memory ports.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  pipeline MEM-stage access request.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid&&req_ready at a clk edge.
REQ-006 SHALL have port req_write  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend.
REQ-009 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  misaligned/illegal access, valid with resp_valid.
REQ-014 SHALL have port stall  output  1  high whenever the FSM is not IDLE.
REQ-015 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  32, mem_read  output  1, mem_write  output  1, mem_rdata  input  32 -- initiator side of the little-endian word memory (byte at mem_addr on [7:0]; combinational read gated by mem_read; write on rising edge of mem_write).

Function
REQ-016 SHALL implement FSM states IDLE, READ, SETUP, WRITE, DONE; req_ready=1 only in IDLE.
REQ-017 SHALL latch all req_* fields on acceptance; inputs ignored outside IDLE.
REQ-018 SHALL flag error when size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=0; erroring request goes IDLE->DONE with resp_err=1, no mem_read/mem_write activity.
REQ-019 SHALL drive mem_addr = {addr[ADDR_W-1:2],2'b00} for all memory phases; address constant from first memory phase through DONE.
REQ-020 Load: IDLE->READ->DONE; mem_read=1 only in READ; word captured from mem_rdata at end of READ; resp_valid two cycles after acceptance edge.
REQ-021 Load extraction: byte lane addr[1:0], halfword lane addr[1]; extend per req_unsigned; word returned unmodified.
REQ-022 Word store: IDLE->SETUP->WRITE->DONE; mem_wdata=req_wdata stable in SETUP, WRITE, DONE; resp_valid three cycles after acceptance.
REQ-023 Byte/halfword store: read-modify-write IDLE->READ->SETUP->WRITE->DONE; merge replaces only addressed lane(s) with req_wdata[7:0]/[15:0]; resp_valid four cycles after acceptance.
REQ-024 mem_write SHALL be a registered output, 1 only in WRITE (exactly one cycle per store), 0 in every other state.
REQ-025 mem_read SHALL be 0 in all states except READ; mem_read and mem_write never both 1.
REQ-026 DONE SHALL last one cycle, assert resp_valid, then return to IDLE; back-to-back requests accepted in the cycle after DONE.
REQ-027 resp_rdata/resp_err SHALL be 0 whenever resp_valid=0.

Reset
REQ-028 On reset: state IDLE, req_ready=1, stall=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-029 Reset in any state (including WRITE) SHALL abort the access with no response; mem_write low from the reset edge; reset dominates simultaneous req_valid.

Verification
REQ-030 lw addr 0x100, memory holds 0x8899AABB -> resp_valid cycle 2, resp_rdata=0x8899AABB, resp_err=0.
REQ-031 lb addr 0x103 then lbu addr 0x103 on same word -> resp_rdata 0xFFFFFF88 then 0x00000088.
REQ-032 sb addr 0x101 wdata 0x12 on word 0x8899AABB -> one mem_write pulse cycle 3, word becomes 0x889912BB, resp cycle 4.
REQ-033 lh addr 0x101, then sw addr 0x102 -> both resp_err=1 one cycle after acceptance, mem_read/mem_write never asserted.
REQ-034 sw addr 0x200 wdata 0xDEADBEEF with reset asserted during SETUP -> no mem_write pulse, no resp_valid, memory unchanged, IDLE next cycle.
REQ-035 Back-to-back sw 0x10 then lw 0x10 with req_valid held -> lw returns 0xDEADBEEF-style written value, stall high throughout except IDLE cycles.
